// File: rtl/pixel_plot_writer.sv
// -----------------------------------------------------------------------------
// pixel_plot_writer
//   Turns single-pixel plot requests from a line drawer into framebuffer word
//   writes. Off-screen pixels are discarded and counted. A completion pulse
//   (done) is issued once per request, and a held request is never written
//   twice: the block waits in RELEASE until plot drops.
//
// Ports
//   clk         clock
//   rst         asynchronous, active-low reset
//   plot        plot request (level, held until done)
//   x, y        signed pixel column / row
//   color       pixel value
//   done        one-cycle completion pulse
//   busy        high whenever the FSM is not in IDLE
//   mem_wr_req  framebuffer write request (held until mem_ack)
//   mem_addr    framebuffer word address, y*H_RES + x
//   mem_wdata   framebuffer write data
//   mem_ack     framebuffer write accept (may coincide with the request)
//   plot_count  completed writes, saturating
//   clip_count  discarded requests, saturating
// -----------------------------------------------------------------------------
module pixel_plot_writer #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                plot,
    input  logic signed [31:0]  x,
    input  logic signed [31:0]  y,
    input  logic [COLOR_W-1:0]  color,
    output logic                done,
    output logic                busy,
    output logic                mem_wr_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOR_W-1:0]  mem_wdata,
    input  logic                mem_ack,
    output logic [15:0]         plot_count,
    output logic [15:0]         clip_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t               state_r;
    logic signed [31:0]   x_r;
    logic signed [31:0]   y_r;
    logic [COLOR_W-1:0]   color_r;
    logic                 clip_r;
    logic                 done_r;
    logic                 busy_r;
    logic                 mem_wr_req_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [COLOR_W-1:0]   mem_wdata_r;
    logic [15:0]          plot_count_r;
    logic [15:0]          clip_count_r;

    logic                 clip_s;
    logic [ADDR_W-1:0]    addr_s;

    // Counters stick at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc = 16'hFFFF;
        end else begin
            sat_inc = value + 16'd1;
        end
    endfunction

    // Off-screen test on the live request, captured together with x/y/color.
    always_comb begin
        clip_s = 1'b0;
        if ((x < 32'sd0) || (x >= H_RES) || (y < 32'sd0) || (y >= V_RES)) begin
            clip_s = 1'b1;
        end else begin
            clip_s = 1'b0;
        end
    end

    // Linear word address from the captured coordinates, truncated to ADDR_W.
    always_comb begin
        addr_s = ADDR_W'(y_r * H_RES + x_r);
    end

    // Request FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            x_r          <= 32'sd0;
            y_r          <= 32'sd0;
            color_r      <= '0;
            clip_r       <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            mem_wr_req_r <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            plot_count_r <= 16'd0;
            clip_count_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (plot) begin
                        x_r     <= x;
                        y_r     <= y;
                        color_r <= color;
                        clip_r  <= clip_s;
                        busy_r  <= 1'b1;
                        state_r <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (clip_r) begin
                        clip_count_r <= sat_inc(clip_count_r);
                        done_r       <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        mem_addr_r   <= addr_s;
                        mem_wdata_r  <= color_r;
                        mem_wr_req_r <= 1'b1;
                        state_r      <= WRITE;
                    end
                end
                WRITE: begin
                    // Address and data stay put until the framebuffer accepts.
                    if (mem_ack) begin
                        mem_wr_req_r <= 1'b0;
                        plot_count_r <= sat_inc(plot_count_r);
                        done_r       <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= RELEASE;
                end
                RELEASE: begin
                    // Wait for the drawer to drop plot so one request = one write.
                    if (!plot) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= RELEASE;
                    end
                end
                default: begin
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    mem_wr_req_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign done       = done_r;
    assign busy       = busy_r;
    assign mem_wr_req = mem_wr_req_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign plot_count = plot_count_r;
    assign clip_count = clip_count_r;

endmodule
